uart_tx_arbiter: RTL and testbench

Shares the board's single UART transmit line (`uart_tx_out`) between several byte-producing requesters, such as the RX echo path and a status/LED reporter. Arbitration is round-robin at byte granularity. The block serializes each granted byte as an 8N1 frame at a fixed baud rate. It sits at the top level between the requester logic and the `uart_tx_out` pin.

---
 rtl/uart_tx_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 451 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Purpose: round-robin byte arbiter sharing one 8N1 UART transmit line among N_REQ requesters.
// Latency: req_ready is combinational in IDLE; the start bit begins on the accepting edge; a frame lasts 10*DIV cycles.
// Backpressure: req_ready stays low for the whole frame; pending requests wait (or withdraw), nothing is dropped.
//
// Ports:
//   gclk, rst          clock and synchronous active-high reset
//   req_valid[i]       requester i has a byte pending on req_data[8i+7:8i]
//   req_ready[i]       one-hot accept strobe, only in IDLE
//   uart_tx_out        serial line, idle high, registered
//   busy               frame in flight, registered
//   grant_idx          index of the last accepted requester, registered
module uart_tx_arbiter #(
    parameter int CLK_HZ = 100_000_000,
    parameter int BAUD   = 115200,
    parameter int N_REQ  = 2,
    localparam int IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                 gclk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [8*N_REQ-1:0]   req_data,
    output logic [N_REQ-1:0]     req_ready,
    output logic                 uart_tx_out,
    output logic                 busy,
    output logic [IW-1:0]        grant_idx
);

    localparam int DIV = CLK_HZ / BAUD;
    localparam int CW  = $clog2(DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(N_REQ - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [2:0]    bit_idx, bit_idx_nxt;
    logic [7:0]    shreg, shreg_nxt;
    logic [IW-1:0] ptr, ptr_nxt;
    logic [IW-1:0] grant_nxt;
    logic          tx_nxt;
    logic          busy_nxt;

    logic          pick_vld;
    logic          hi_vld;
    logic [IW-1:0] hi_idx;
    logic [IW-1:0] lo_idx;
    logic [IW-1:0] pick_idx;
    logic [7:0]    pick_dat;
    logic          accept;
    logic          cnt_done;

    // Round-robin pick: the lowest valid index at or above ptr wins; if none
    // exists the scan wraps and the lowest valid index overall wins.
    // Iterating downwards lets the last assignment be the lowest index.
    always_comb begin
        hi_vld   = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        pick_vld = 1'b0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                pick_vld = 1'b1;
                lo_idx   = IW'(i);
                if (IW'(i) >= ptr) begin
                    hi_vld = 1'b1;
                    hi_idx = IW'(i);
                end
            end
        end
        pick_idx = hi_vld ? hi_idx : lo_idx;
    end

    always_comb begin
        pick_dat = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick_idx == IW'(i)) begin
                pick_dat = req_data[8*i +: 8];
            end
        end
    end

    // Reset wins over a simultaneous request, so ready is masked by rst.
    assign accept = (state == IDLE) && !rst && pick_vld;

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < N_REQ; i++) begin
            req_ready[i] = accept && (pick_idx == IW'(i));
        end
    end

    assign cnt_done = (cnt == CNT_LAST);

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        bit_idx_nxt = bit_idx;
        shreg_nxt   = shreg;
        ptr_nxt     = ptr;
        grant_nxt   = grant_idx;
        tx_nxt      = uart_tx_out;
        busy_nxt    = busy;

        unique case (state)
            IDLE: begin
                if (accept) begin
                    shreg_nxt = pick_dat;
                    grant_nxt = pick_idx;
                    ptr_nxt   = (pick_idx == IDX_LAST) ? '0 : pick_idx + 1'b1;
                    tx_nxt    = 1'b0;
                    busy_nxt  = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = START;
                end
            end
            START: begin
                if (cnt_done) begin
                    cnt_nxt     = '0;
                    bit_idx_nxt = '0;
                    tx_nxt      = shreg[0];
                    state_nxt   = DATA;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            DATA: begin
                if (cnt_done) begin
                    cnt_nxt = '0;
                    if (bit_idx == 3'd7) begin
                        tx_nxt    = 1'b1;
                        state_nxt = STOP;
                    end else begin
                        // The bit after the shift is shreg[1] of the current value.
                        bit_idx_nxt = bit_idx + 1'b1;
                        shreg_nxt   = {1'b0, shreg[7:1]};
                        tx_nxt      = shreg[1];
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            STOP: begin
                if (cnt_done) begin
                    cnt_nxt   = '0;
                    busy_nxt  = 1'b0;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge gclk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            bit_idx     <= '0;
            shreg       <= '0;
            ptr         <= '0;
            grant_idx   <= '0;
            uart_tx_out <= 1'b1;
            busy        <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            bit_idx     <= bit_idx_nxt;
            shreg       <= shreg_nxt;
            ptr         <= ptr_nxt;
            grant_idx   <= grant_nxt;
            uart_tx_out <= tx_nxt;
            busy        <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter with DIV = 10, two requesters.
// Directed scenarios plus randomized traffic against a frame-level reference model.
// Inputs change on the falling edge; outputs are sampled on the falling edge or 1 time unit after it.
module tb_uart_tx_arbiter;

    localparam int DIV = 10;

    logic        gclk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic [15:0] req_data;
    logic [1:0]  req_ready;
    logic        uart_tx_out;
    logic        busy;
    logic [0:0]  grant_idx;

    int checks = 0;
    int errors = 0;

    always #5 gclk = ~gclk;

    uart_tx_arbiter #(
        .CLK_HZ(1000),
        .BAUD  (100),
        .N_REQ (2)
    ) dut (
        .gclk       (gclk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .uart_tx_out(uart_tx_out),
        .busy       (busy),
        .grant_idx  (grant_idx)
    );

    // ---------------- reference model (frame level) ----------------
    bit         m_inflight = 1'b0;
    int         m_off      = 0;
    logic [7:0] m_byte     = 8'h00;
    int         m_ptr      = 0;
    int         m_grant    = 0;
    bit         m_acc_vld  = 1'b0;
    int         m_acc_idx  = 0;
    int         m_w;
    int         rst_cnt    = 0;
    logic [7:0] m_bytes[$];

    function automatic int winner(input logic [1:0] v, input int p);
        for (int k = 0; k < 2; k++) begin
            if (v[(p + k) % 2]) return (p + k) % 2;
        end
        return -1;
    endfunction

    // Line level at a given offset from the accepting edge of a frame.
    function automatic logic exp_line(input bit inflight, input int off, input logic [7:0] b);
        if (!inflight) return 1'b1;
        if (off < DIV) return 1'b0;
        if (off < 9*DIV) return b[(off - DIV) / DIV];
        return 1'b1;
    endfunction

    function automatic logic [1:0] exp_ready(input bit inflight, input logic [1:0] v, input int p);
        int w;
        if (inflight) return 2'b00;
        w = winner(v, p);
        if (w < 0) return 2'b00;
        return (w == 0) ? 2'b01 : 2'b10;
    endfunction

    always @(posedge gclk) begin
        m_acc_vld = 1'b0;
        if (rst) begin
            m_inflight = 1'b0;
            m_off      = 0;
            m_ptr      = 0;
            m_grant    = 0;
            rst_cnt++;
        end else if (m_inflight) begin
            m_off++;
            if (m_off == 10*DIV) m_inflight = 1'b0;
        end else begin
            m_w = winner(req_valid, m_ptr);
            if (m_w >= 0) begin
                m_inflight = 1'b1;
                m_off      = 0;
                m_byte     = req_data[8*m_w +: 8];
                m_grant    = m_w;
                m_ptr      = (m_w + 1) % 2;
                m_acc_vld  = 1'b1;
                m_acc_idx  = m_w;
                m_bytes.push_back(m_byte);
            end
        end
    end

    // ---------------- line monitor (mid-bit sampling decoder) ----------------
    logic [7:0] mon_bytes[$];
    int         mon_start[$];
    bit         mon_bad[$];
    int         ncyc        = 0;
    bit         mon_active  = 1'b0;
    int         mon_cnt     = 0;
    int         mon_sc      = 0;
    logic [7:0] mon_sh      = 8'h00;
    bit         mon_err     = 1'b0;
    logic       mon_prev    = 1'b1;
    int         mon_rst_seen = 0;

    always @(negedge gclk) begin
        ncyc++;
        if (mon_rst_seen != rst_cnt) begin
            mon_active   = 1'b0;
            mon_rst_seen = rst_cnt;
        end else if (!mon_active) begin
            if (uart_tx_out === 1'b0 && mon_prev === 1'b1) begin
                mon_active = 1'b1;
                mon_cnt    = 0;
                mon_sh     = 8'h00;
                mon_err    = 1'b0;
                mon_sc     = ncyc;
            end
        end else begin
            mon_cnt++;
            if (mon_cnt == DIV/2 && uart_tx_out !== 1'b0) mon_err = 1'b1;
            if (mon_cnt > DIV && mon_cnt < 9*DIV && (mon_cnt % DIV) == DIV/2)
                mon_sh = {uart_tx_out, mon_sh[7:1]};
            if (mon_cnt == 9*DIV + DIV/2) begin
                if (uart_tx_out !== 1'b1) mon_err = 1'b1;
                mon_bytes.push_back(mon_sh);
                mon_start.push_back(mon_sc);
                mon_bad.push_back(mon_err);
                mon_active = 1'b0;
            end
        end
        mon_prev = uart_tx_out;
    end

    // ---------------- scenarios ----------------
    task automatic do_reset(input logic [1:0] v);
        @(negedge gclk);
        rst       = 1'b1;
        req_valid = v;
        @(negedge gclk);
        @(negedge gclk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        int lows;
        req_data = 16'hB2A1;
        @(negedge gclk);
        rst       = 1'b1;
        req_valid = 2'b11;
        @(negedge gclk);
        checks++; if (uart_tx_out !== 1'b1) begin errors++; $display("FAIL reset_tx got %b want 1", uart_tx_out); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (grant_idx !== 1'b0) begin errors++; $display("FAIL reset_grant got %b want 0", grant_idx); end
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_ready_masked got %b want 00", req_ready); end
        rst       = 1'b0;
        req_valid = 2'b00;
        lows = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge gclk);
            if (uart_tx_out !== 1'b1 || busy !== 1'b0) lows++;
        end
        checks++; if (lows != 0) begin errors++; $display("FAIL reset_idle_line got %0d active cycles want 0", lows); end
    endtask

    task automatic test_single();
        int base, busy_cycles, wave_err;
        do_reset(2'b00);
        base = mon_bytes.size();
        req_data[7:0] = 8'h55;
        req_valid     = 2'b01;
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL single_ready got %b want 01", req_ready); end
        @(negedge gclk);
        req_valid   = 2'b00;
        busy_cycles = 0;
        wave_err    = 0;
        for (int k = 0; k < 12*DIV; k++) begin
            if (k > 0) @(negedge gclk);
            if (uart_tx_out !== exp_line(1'b1, k, 8'h55)) wave_err++;
            if (busy === 1'b1) busy_cycles++;
        end
        checks++; if (wave_err != 0) begin errors++; $display("FAIL single_wave got %0d wrong cycles want 0", wave_err); end
        checks++; if (busy_cycles != 10*DIV) begin errors++; $display("FAIL single_busy got %0d want %0d", busy_cycles, 10*DIV); end
        checks++; if (grant_idx !== 1'b0) begin errors++; $display("FAIL single_grant got %b want 0", grant_idx); end
        checks++;
        if (mon_bytes.size() != base + 1 || mon_bytes[base] !== 8'h55 || mon_bad[base]) begin
            errors++; $display("FAIL single_decode got %0d frames want 1 frame of 55", mon_bytes.size() - base);
        end
    endtask

    task automatic test_contention();
        int base, rdy_busy;
        int grants[$];
        logic [1:0] cur, rdy_prev;
        req_data = 16'hB2A1;
        do_reset(2'b11);
        base     = mon_bytes.size();
        rdy_prev = 2'b00;
        rdy_busy = 0;
        for (int k = 0; k < 260; k++) begin
            #1;
            cur = req_ready;
            if (k == 0) begin
                checks++; if (cur !== 2'b01) begin errors++; $display("FAIL cont_first_ready got %b want 01", cur); end
            end
            if (cur !== 2'b00 && busy === 1'b1) rdy_busy++;
            for (int i = 0; i < 2; i++) begin
                if (rdy_prev[i]) begin
                    req_valid[i] = 1'b0;
                    grants.push_back(int'(grant_idx));
                end
            end
            rdy_prev = cur;
            @(negedge gclk);
        end
        checks++;
        if (grants.size() != 2) begin
            errors++; $display("FAIL cont_grant_count got %0d want 2", grants.size());
        end else begin
            checks++; if (grants[0] != 0 || grants[1] != 1) begin errors++; $display("FAIL cont_grant_order got %0d,%0d want 0,1", grants[0], grants[1]); end
        end
        checks++;
        if (mon_bytes.size() != base + 2) begin
            errors++; $display("FAIL cont_frames got %0d want 2", mon_bytes.size() - base);
        end else begin
            checks++; if (mon_bytes[base] !== 8'hA1 || mon_bytes[base+1] !== 8'hB2) begin
                errors++; $display("FAIL cont_bytes got %h,%h want a1,b2", mon_bytes[base], mon_bytes[base+1]);
            end
            checks++; if (mon_start[base+1] - mon_start[base] != 10*DIV + 1) begin
                errors++; $display("FAIL cont_gap got %0d want %0d", mon_start[base+1] - mon_start[base], 10*DIV + 1);
            end
        end
        checks++; if (rdy_busy != 0) begin errors++; $display("FAIL cont_ready_while_busy got %0d want 0", rdy_busy); end
    endtask

    task automatic test_fairness();
        int base, rdy_busy, acc;
        int grants[$];
        logic [7:0] exp_q[$];
        logic [1:0] cur, rdy_prev;
        req_data = 16'($urandom);
        do_reset(2'b11);
        base     = mon_bytes.size();
        rdy_prev = 2'b00;
        rdy_busy = 0;
        acc      = 0;
        for (int k = 0; k < 6*(10*DIV + 1) + 12*DIV; k++) begin
            #1;
            cur = req_ready;
            if (cur !== 2'b00 && busy === 1'b1) rdy_busy++;
            for (int i = 0; i < 2; i++) begin
                if (rdy_prev[i]) begin
                    grants.push_back(int'(grant_idx));
                    acc++;
                    req_data[8*i +: 8] = 8'($urandom);
                    if (acc == 6) req_valid = 2'b00;
                end
                if (cur[i]) exp_q.push_back(req_data[8*i +: 8]);
            end
            rdy_prev = cur;
            @(negedge gclk);
        end
        checks++;
        if (grants.size() != 6) begin
            errors++; $display("FAIL fair_grant_count got %0d want 6", grants.size());
        end else begin
            for (int j = 0; j < 6; j++) begin
                checks++; if (grants[j] != j % 2) begin errors++; $display("FAIL fair_grant[%0d] got %0d want %0d", j, grants[j], j % 2); end
            end
        end
        checks++;
        if (mon_bytes.size() != base + exp_q.size()) begin
            errors++; $display("FAIL fair_frames got %0d want %0d", mon_bytes.size() - base, exp_q.size());
        end else begin
            for (int j = 0; j < exp_q.size(); j++) begin
                checks++; if (mon_bytes[base+j] !== exp_q[j] || mon_bad[base+j]) begin
                    errors++; $display("FAIL fair_byte[%0d] got %h want %h", j, mon_bytes[base+j], exp_q[j]);
                end
            end
        end
        checks++; if (rdy_busy != 0) begin errors++; $display("FAIL fair_ready_while_busy got %0d want 0", rdy_busy); end
    endtask

    task automatic test_reset_midframe();
        int base, lows;
        do_reset(2'b00);
        base            = mon_bytes.size();
        req_data[15:8]  = 8'h00;
        req_valid       = 2'b10;
        @(negedge gclk);
        req_valid = 2'b00;
        checks++; if (grant_idx !== 1'b1 || busy !== 1'b1) begin
            errors++; $display("FAIL mid_pre got grant=%b busy=%b want 1,1", grant_idx, busy);
        end
        repeat (44) @(negedge gclk);
        rst = 1'b1;
        @(negedge gclk);
        checks++; if (uart_tx_out !== 1'b1) begin errors++; $display("FAIL mid_tx got %b want 1", uart_tx_out); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy got %b want 0", busy); end
        checks++; if (grant_idx !== 1'b0) begin errors++; $display("FAIL mid_grant got %b want 0", grant_idx); end
        rst  = 1'b0;
        lows = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge gclk);
            if (uart_tx_out !== 1'b1) lows++;
        end
        checks++; if (lows != 0) begin errors++; $display("FAIL mid_line_after got %0d low cycles want 0", lows); end
        req_data[7:0] = 8'h3C;
        req_valid     = 2'b01;
        @(negedge gclk);
        req_valid = 2'b00;
        repeat (11*DIV) @(negedge gclk);
        checks++;
        if (mon_bytes.size() != base + 1 || mon_bytes[base] !== 8'h3C || mon_bad[base]) begin
            errors++; $display("FAIL mid_followup got %0d frames want 1 clean frame of 3c", mon_bytes.size() - base);
        end
    endtask

    task automatic test_withdraw();
        int base, rdy1, lows;
        do_reset(2'b00);
        base     = mon_bytes.size();
        req_data = {8'h11, 8'h96};
        req_valid = 2'b01;
        @(negedge gclk);
        req_valid = 2'b00;
        repeat (29) @(negedge gclk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL wd_busy got %b want 1", busy); end
        req_valid[1] = 1'b1;
        @(negedge gclk);
        req_valid[1] = 1'b0;
        rdy1 = 0;
        lows = 0;
        for (int k = 0; k < 150; k++) begin
            #1;
            if (req_ready[1] === 1'b1) rdy1++;
            if (k >= 70 && uart_tx_out !== 1'b1) lows++;
            @(negedge gclk);
        end
        checks++; if (rdy1 != 0) begin errors++; $display("FAIL wd_ready1 got %0d want 0", rdy1); end
        checks++; if (lows != 0) begin errors++; $display("FAIL wd_line got %0d low cycles want 0", lows); end
        checks++;
        if (mon_bytes.size() != base + 1 || mon_bytes[base] !== 8'h96) begin
            errors++; $display("FAIL wd_frames got %0d frames want only 96", mon_bytes.size() - base);
        end
    endtask

    task automatic test_back_to_back();
        int base, wave_err, lows;
        logic e;
        do_reset(2'b00);
        base           = mon_bytes.size();
        req_data[15:8] = 8'hFF;
        req_valid      = 2'b10;
        @(negedge gclk);
        wave_err = 0;
        lows     = 0;
        for (int k = 0; k < 230; k++) begin
            e = (k < 10*DIV + 1) ? exp_line(1'b1, k, 8'hFF) : exp_line(1'b1, k - (10*DIV + 1), 8'h00);
            if (uart_tx_out !== e) wave_err++;
            if (uart_tx_out === 1'b0) lows++;
            if (k == 0) begin
                checks++; if (grant_idx !== 1'b1) begin errors++; $display("FAIL b2b_grant got %b want 1", grant_idx); end
                req_data[15:8] = 8'h00;
            end
            if (k == 10*DIV + 1) req_valid = 2'b00;
            @(negedge gclk);
        end
        checks++; if (wave_err != 0) begin errors++; $display("FAIL b2b_wave got %0d wrong cycles want 0", wave_err); end
        checks++; if (lows != 10*DIV) begin errors++; $display("FAIL b2b_low_cycles got %0d want %0d", lows, 10*DIV); end
        checks++;
        if (mon_bytes.size() != base + 2) begin
            errors++; $display("FAIL b2b_frames got %0d want 2", mon_bytes.size() - base);
        end else begin
            checks++; if (mon_bytes[base] !== 8'hFF || mon_bytes[base+1] !== 8'h00 || mon_bad[base] || mon_bad[base+1]) begin
                errors++; $display("FAIL b2b_bytes got %h,%h want ff,00", mon_bytes[base], mon_bytes[base+1]);
            end
        end
    endtask

    task automatic test_random();
        int mbase, mmbase, n;
        do_reset(2'b00);
        mbase  = mon_bytes.size();
        mmbase = m_bytes.size();
        for (int k = 0; k < 3000; k++) begin
            @(negedge gclk);
            checks++; if (uart_tx_out !== exp_line(m_inflight, m_off, m_byte)) begin
                errors++; $display("FAIL rnd_tx cyc %0d got %b want %b", k, uart_tx_out, exp_line(m_inflight, m_off, m_byte));
            end
            checks++; if (busy !== m_inflight) begin errors++; $display("FAIL rnd_busy cyc %0d got %b want %b", k, busy, m_inflight); end
            checks++; if (grant_idx !== 1'(m_grant)) begin errors++; $display("FAIL rnd_grant cyc %0d got %b want %0d", k, grant_idx, m_grant); end
            checks++; if (req_ready !== exp_ready(m_inflight, req_valid, m_ptr)) begin
                errors++; $display("FAIL rnd_ready cyc %0d got %b want %b", k, req_ready, exp_ready(m_inflight, req_valid, m_ptr));
            end
            for (int i = 0; i < 2; i++) begin
                if (m_acc_vld && m_acc_idx == i) begin
                    req_valid[i]       = 1'($urandom_range(0, 1));
                    req_data[8*i +: 8] = 8'($urandom);
                end else if (req_valid[i]) begin
                    if ($urandom_range(0, 19) == 0) req_valid[i] = 1'b0;
                end else if ($urandom_range(0, 5) == 0) begin
                    req_data[8*i +: 8] = 8'($urandom);
                    req_valid[i]       = 1'b1;
                end
            end
        end
        req_valid = 2'b00;
        repeat (12*DIV) @(negedge gclk);
        n = m_bytes.size() - mmbase;
        checks++;
        if (mon_bytes.size() - mbase != n) begin
            errors++; $display("FAIL rnd_frames got %0d want %0d", mon_bytes.size() - mbase, n);
        end else begin
            for (int j = 0; j < n; j++) begin
                checks++; if (mon_bytes[mbase+j] !== m_bytes[mmbase+j] || mon_bad[mbase+j]) begin
                    errors++; $display("FAIL rnd_byte[%0d] got %h want %h", j, mon_bytes[mbase+j], m_bytes[mmbase+j]);
                end
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 2'b00;
        req_data  = 16'h0000;
        test_reset();
        test_single();
        test_contention();
        test_fairness();
        test_reset_midframe();
        test_withdraw();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
